// File: rtl/cmp_ge_serial_if.sv
// Handshake bundle for the digit-serial comparator: operand channel in,
// result channel out. The master side supplies operands and consumes results.
interface cmp_ge_serial_if #(
    parameter int width = 8
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [width-1:0] A_i;
    logic [width-1:0] B_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic             GE_o;
    logic             GT_o;
    logic             EQ_o;

    modport master (
        output in_valid_i, A_i, B_i, out_ready_i,
        input  in_ready_o, out_valid_o, GE_o, GT_o, EQ_o
    );

    modport slave (
        input  in_valid_i, A_i, B_i, out_ready_i,
        output in_ready_o, out_valid_o, GE_o, GT_o, EQ_o
    );
endinterface

// File: rtl/cmp_ge_serial.sv
// Digit-serial magnitude comparator. Operands are scanned MSB-first, `digit`
// bits per cycle, and the scan stops at the first differing digit. Signed
// operands are mapped to offset binary at capture so the scan is unsigned.
module cmp_ge_serial #(
    parameter int width = 8,
    parameter int digit = 2,
    parameter int sgn   = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    cmp_ge_serial_if.slave   bus
);
    localparam int N  = width / digit;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Inverting the sign bit turns two's-complement order into unsigned order.
    localparam logic [width-1:0] SIGN_FLIP =
        (sgn != 0) ? (width'(1) << (width - 1)) : '0;

    logic [1:0]       r_state;
    logic [width-1:0] r_ra;
    logic [width-1:0] r_rb;
    logic [CW-1:0]    r_cnt;
    logic             r_ge;
    logic             r_gt;
    logic             r_eq;

    logic [digit-1:0] w_da;
    logic [digit-1:0] w_db;
    logic             w_accept;
    logic             w_scan;
    logic             w_diff;
    logic             w_last;

    assign w_da     = r_ra[width-1 -: digit];
    assign w_db     = r_rb[width-1 -: digit];
    assign w_accept = (r_state == S_IDLE) && bus.in_valid_i;
    assign w_scan   = (r_state == S_SCAN);
    assign w_diff   = (w_da != w_db);
    assign w_last   = (r_cnt == '0);

    // Handshake flags come straight from state, never from inputs.
    assign bus.in_ready_o  = (r_state == S_IDLE);
    assign bus.out_valid_o = (r_state == S_DONE);
    assign bus.GE_o        = r_ge;
    assign bus.GT_o        = r_gt;
    assign bus.EQ_o        = r_eq;

    // Control: accept, scan until a difference or the last digit, hold result.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (bus.in_valid_i)     r_state <= S_SCAN;
                S_SCAN:  if (w_diff || w_last)   r_state <= S_DONE;
                S_DONE:  if (bus.out_ready_i)    r_state <= S_IDLE;
                default:                         r_state <= S_IDLE;
            endcase
        end
    end

    // Operand shift registers and digit counter; bus sampled only on accept.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ra  <= '0;
            r_rb  <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_ra  <= bus.A_i ^ SIGN_FLIP;
            r_rb  <= bus.B_i ^ SIGN_FLIP;
            r_cnt <= CW'(N - 1);
        end else if (w_scan && !w_diff && !w_last) begin
            r_ra  <= r_ra << digit;
            r_rb  <= r_rb << digit;
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // Result flags: written once per operation, held until the next result.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ge <= 1'b0;
            r_gt <= 1'b0;
            r_eq <= 1'b0;
        end else if (w_scan && w_diff) begin
            r_gt <= (w_da > w_db);
            r_ge <= (w_da > w_db);
            r_eq <= 1'b0;
        end else if (w_scan && w_last) begin
            r_gt <= 1'b0;
            r_ge <= 1'b1;
            r_eq <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cmp_ge_serial.sv
// Directed bench for cmp_ge_serial: one DUT at default parameters plus a
// signed instance and digit = 1/4/8 instances sharing clock and reset.
module tb_cmp_ge_serial;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    int       alat [4];
    logic [2:0] ares [4];

    always #5 clk = ~clk;

    cmp_ge_serial_if #(.width(8)) bus0 ();
    cmp_ge_serial_if #(.width(8)) bus_s ();
    cmp_ge_serial_if #(.width(8)) bus_1 ();
    cmp_ge_serial_if #(.width(8)) bus_4 ();
    cmp_ge_serial_if #(.width(8)) bus_8 ();

    cmp_ge_serial #(.width(8), .digit(2), .sgn(0)) u_dut   (.clk_i(clk), .rst_i(rst), .bus(bus0));
    cmp_ge_serial #(.width(8), .digit(2), .sgn(1)) u_sgn   (.clk_i(clk), .rst_i(rst), .bus(bus_s));
    cmp_ge_serial #(.width(8), .digit(1), .sgn(0)) u_dig1  (.clk_i(clk), .rst_i(rst), .bus(bus_1));
    cmp_ge_serial #(.width(8), .digit(4), .sgn(0)) u_dig4  (.clk_i(clk), .rst_i(rst), .bus(bus_4));
    cmp_ge_serial #(.width(8), .digit(8), .sgn(0)) u_dig8  (.clk_i(clk), .rst_i(rst), .bus(bus_8));

    // Start one operation on the main DUT; optionally drive junk while scanning.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit junk,
                          output int lat, output logic ge, output logic gt, output logic eq);
        @(negedge clk);
        bus0.A_i = a; bus0.B_i = b; bus0.in_valid_i = 1'b1; bus0.out_ready_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if (junk) begin
            bus0.A_i = 8'hFF; bus0.B_i = 8'h00;
        end else begin
            bus0.in_valid_i = 1'b0;
        end
        lat = 0;
        while (!bus0.out_valid_o && lat < 20) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        bus0.in_valid_i = 1'b0;
        ge = bus0.GE_o; gt = bus0.GT_o; eq = bus0.EQ_o;
    endtask

    task automatic drain0();
        @(negedge clk);
        bus0.out_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus0.out_ready_i = 1'b0;
    endtask

    task automatic set_aux(input logic [7:0] a, input logic [7:0] b, input logic v, input logic r);
        bus_s.A_i = a; bus_s.B_i = b; bus_s.in_valid_i = v; bus_s.out_ready_i = r;
        bus_1.A_i = a; bus_1.B_i = b; bus_1.in_valid_i = v; bus_1.out_ready_i = r;
        bus_4.A_i = a; bus_4.B_i = b; bus_4.in_valid_i = v; bus_4.out_ready_i = r;
        bus_8.A_i = a; bus_8.B_i = b; bus_8.in_valid_i = v; bus_8.out_ready_i = r;
    endtask

    // Run one operand pair on all auxiliary DUTs, recording each latency.
    task automatic run_aux(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        set_aux(a, b, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        set_aux(a, b, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) alat[k] = -1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (alat[0] < 0 && bus_s.out_valid_o) alat[0] = c;
            if (alat[1] < 0 && bus_1.out_valid_o) alat[1] = c;
            if (alat[2] < 0 && bus_4.out_valid_o) alat[2] = c;
            if (alat[3] < 0 && bus_8.out_valid_o) alat[3] = c;
        end
        ares[0] = {bus_s.GE_o, bus_s.GT_o, bus_s.EQ_o};
        ares[1] = {bus_1.GE_o, bus_1.GT_o, bus_1.EQ_o};
        ares[2] = {bus_4.GE_o, bus_4.GT_o, bus_4.EQ_o};
        ares[3] = {bus_8.GE_o, bus_8.GT_o, bus_8.EQ_o};
        set_aux(a, b, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_aux(a, b, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        total++; if (bus0.in_ready_o !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", bus0.in_ready_o); end
        total++; if (bus0.out_valid_o !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus0.out_valid_o); end
        total++; if ({bus0.GE_o, bus0.GT_o, bus0.EQ_o} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {bus0.GE_o, bus0.GT_o, bus0.EQ_o}); end
        rst = 1'b0;
    endtask

    task automatic test_early_exit();
        int lat; logic ge, gt, eq;
        run_op(8'hC3, 8'h3C, 1'b0, lat, ge, gt, eq);
        total++; if (lat !== 1) begin bad++; $display("FAIL early_lat: got %0d want 1", lat); end
        total++; if ({ge, gt, eq} !== 3'b110) begin bad++; $display("FAIL early_flags: got %b want 110", {ge, gt, eq}); end
        drain0();
        total++; if (bus0.in_ready_o !== 1'b1 || bus0.out_valid_o !== 1'b0) begin bad++; $display("FAIL early_handshake: got rdy=%b vld=%b want rdy=1 vld=0", bus0.in_ready_o, bus0.out_valid_o); end
    endtask

    task automatic test_equal();
        int lat; logic ge, gt, eq;
        run_op(8'h5A, 8'h5A, 1'b0, lat, ge, gt, eq);
        total++; if (lat !== 4) begin bad++; $display("FAIL equal_lat: got %0d want 4", lat); end
        total++; if ({ge, gt, eq} !== 3'b101) begin bad++; $display("FAIL equal_flags: got %b want 101", {ge, gt, eq}); end
        drain0();
    endtask

    task automatic test_last_digit();
        int lat; logic ge, gt, eq;
        run_op(8'h12, 8'h13, 1'b0, lat, ge, gt, eq);
        total++; if (lat !== 4) begin bad++; $display("FAIL lastlo_lat: got %0d want 4", lat); end
        total++; if ({ge, gt, eq} !== 3'b000) begin bad++; $display("FAIL lastlo_flags: got %b want 000", {ge, gt, eq}); end
        drain0();
        run_op(8'h13, 8'h12, 1'b0, lat, ge, gt, eq);
        total++; if (lat !== 4) begin bad++; $display("FAIL lasthi_lat: got %0d want 4", lat); end
        total++; if ({ge, gt, eq} !== 3'b110) begin bad++; $display("FAIL lasthi_flags: got %b want 110", {ge, gt, eq}); end
        drain0();
    endtask

    task automatic test_ignored_input();
        int lat; logic ge, gt, eq;
        // Junk pair FF/00 would give GT after one digit if it were captured.
        run_op(8'h12, 8'h13, 1'b1, lat, ge, gt, eq);
        total++; if (lat !== 4) begin bad++; $display("FAIL ignore_lat: got %0d want 4", lat); end
        total++; if ({ge, gt, eq} !== 3'b000) begin bad++; $display("FAIL ignore_flags: got %b want 000", {ge, gt, eq}); end
        drain0();
    endtask

    task automatic test_backpressure();
        int lat; logic ge, gt, eq;
        run_op(8'hC3, 8'h3C, 1'b0, lat, ge, gt, eq);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            total++;
            if (bus0.out_valid_o !== 1'b1 || bus0.in_ready_o !== 1'b0 ||
                {bus0.GE_o, bus0.GT_o, bus0.EQ_o} !== 3'b110) begin
                bad++;
                $display("FAIL hold_cycle%0d: got vld=%b rdy=%b flags=%b want vld=1 rdy=0 flags=110",
                         c, bus0.out_valid_o, bus0.in_ready_o, {bus0.GE_o, bus0.GT_o, bus0.EQ_o});
            end
        end
        // Leave this result pending for the reset test.
    endtask

    task automatic test_reset_mid_scan();
        int lat; logic ge, gt, eq;
        drain0();
        @(negedge clk);
        bus0.A_i = 8'h12; bus0.B_i = 8'h13; bus0.in_valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus0.in_valid_i = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++; if (bus0.in_ready_o !== 1'b1 || bus0.out_valid_o !== 1'b0) begin bad++; $display("FAIL rst_async_hs: got rdy=%b vld=%b want rdy=1 vld=0", bus0.in_ready_o, bus0.out_valid_o); end
        total++; if ({bus0.GE_o, bus0.GT_o, bus0.EQ_o} !== 3'b000) begin bad++; $display("FAIL rst_async_flags: got %b want 000", {bus0.GE_o, bus0.GT_o, bus0.EQ_o}); end
        @(negedge clk);
        rst = 1'b0;
        run_op(8'h00, 8'hFF, 1'b0, lat, ge, gt, eq);
        total++; if (lat !== 1) begin bad++; $display("FAIL post_rst_lat: got %0d want 1", lat); end
        total++; if ({ge, gt, eq} !== 3'b000) begin bad++; $display("FAIL post_rst_flags: got %b want 000", {ge, gt, eq}); end
        drain0();
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            total++; if (bus0.out_valid_o !== 1'b0) begin bad++; $display("FAIL stale_result%0d: got vld=%b want 0", c, bus0.out_valid_o); end
        end
    endtask

    task automatic test_signed();
        run_aux(8'h80, 8'h7F);
        total++; if (alat[0] !== 1) begin bad++; $display("FAIL sgn_neg_lat: got %0d want 1", alat[0]); end
        total++; if (ares[0] !== 3'b000) begin bad++; $display("FAIL sgn_neg_flags: got %b want 000", ares[0]); end
        run_aux(8'hFF, 8'hFE);
        total++; if (alat[0] !== 4) begin bad++; $display("FAIL sgn_m1_lat: got %0d want 4", alat[0]); end
        total++; if (ares[0] !== 3'b110) begin bad++; $display("FAIL sgn_m1_flags: got %b want 110", ares[0]); end
    endtask

    task automatic test_digit_sweep();
        run_aux(8'h01, 8'h00);
        total++; if (alat[1] !== 8) begin bad++; $display("FAIL dig1_lat: got %0d want 8", alat[1]); end
        total++; if (ares[1] !== 3'b110) begin bad++; $display("FAIL dig1_flags: got %b want 110", ares[1]); end
        total++; if (alat[2] !== 2) begin bad++; $display("FAIL dig4_lat: got %0d want 2", alat[2]); end
        total++; if (ares[2] !== 3'b110) begin bad++; $display("FAIL dig4_flags: got %b want 110", ares[2]); end
        total++; if (alat[3] !== 1) begin bad++; $display("FAIL dig8_lat: got %0d want 1", alat[3]); end
        total++; if (ares[3] !== 3'b110) begin bad++; $display("FAIL dig8_flags: got %b want 110", ares[3]); end
        run_aux(8'hA5, 8'hA5);
        total++; if (alat[3] !== 1) begin bad++; $display("FAIL dig8_eq_lat: got %0d want 1", alat[3]); end
        total++; if (ares[3] !== 3'b101) begin bad++; $display("FAIL dig8_eq_flags: got %b want 101", ares[3]); end
    endtask

    initial begin
        bus0.A_i = '0; bus0.B_i = '0; bus0.in_valid_i = 1'b0; bus0.out_ready_i = 1'b0;
        set_aux(8'h00, 8'h00, 1'b0, 1'b0);
        test_reset();
        test_early_exit();
        test_equal();
        test_last_digit();
        test_ignored_input();
        test_backpressure();
        test_reset_mid_scan();
        test_signed();
        test_digit_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cmp_ge_serial.md
# cmp_ge_serial

Sequential, digit-serial magnitude comparator that scans two operands MSB-first, computes GE, GT and EQ, and stops as soon as a differing digit is found. It complements the parallel-prefix `CmpGE` family, which resolves LSB-to-MSB in combinational logic. This block is used where area matters more than latency, such as threshold checks in multi-cycle datapaths. Operands enter and results leave through valid/ready handshakes.

## Interface
Parameters:
- `width`, 8: operand word width; ≥ 1.
- `digit`, 2: bits examined per cycle; 1 ≤ digit ≤ width; width must be a multiple of digit. `N = width/digit`.
- `sgn`, 0: 0 = unsigned comparison; 1 = two's-complement comparison.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `in_valid_i`  in  1  operand pair valid.
- `in_ready_o`  out  1  block can accept operands.
- `A_i`  in  width  operand A.
- `B_i`  in  width  operand B.
- `out_valid_o`  out  1  result valid.
- `out_ready_i`  in  1  consumer accepts result.
- `GE_o`  out  1  A ≥ B.
- `GT_o`  out  1  A > B.
- `EQ_o`  out  1  A == B.

## Operation
- FSM states: IDLE, SCAN, DONE. Reset state is IDLE.
- IDLE:
  - `in_ready_o` = 1.
  - On `in_valid_i & in_ready_o`, capture A_i and B_i into shift registers `ra` and `rb`, load digit counter `cnt = N-1`, and go to SCAN.
- Signed capture: if `sgn` = 1, invert bit width-1 of both operands at capture. This offset-binary mapping lets the scan use unsigned logic.
- SCAN, one digit per cycle, operating on the top `digit` bits `da` and `db`:
  - `da != db`: register GT = (da > db), EQ = 0, GE = GT. Go to DONE. This is an early exit.
  - `da == db` and `cnt == 0`: register EQ = 1, GT = 0, GE = 1. Go to DONE.
  - Otherwise: shift `ra` and `rb` left by `digit`, decrement `cnt`, stay in SCAN.
- DONE:
  - `out_valid_o` = 1; GE_o, GT_o and EQ_o are stable.
  - On `out_ready_i`, go to IDLE.
- Invariant: `GE_o = GT_o | EQ_o` always holds. When `out_valid_o` = 1, GT_o and EQ_o are never both 1.
- `in_ready_o` is 0 in SCAN and DONE. `in_valid_i`, `A_i` and `B_i` are ignored there. The input data bus is sampled only on the accept edge.
- Result outputs are registered. They hold their last value while not in DONE, and consumers use them only when `out_valid_o` = 1.
- `digit = width`: the comparison always resolves in one SCAN cycle.

## Timing
- Reset values:
  - State IDLE, so `in_ready_o` = 1.
  - `out_valid_o` = 0.
  - GE_o, GT_o, EQ_o = 0.
  - `ra`, `rb`, `cnt` = 0.
- Latency, counted from the accept edge E0:
  - If the first differing digit is index j (0 = most significant), `out_valid_o` rises after edge E(j+1).
  - If the operands are equal, `out_valid_o` rises after edge E(N).
- Output handshake: the result is consumed on the edge where `out_valid_o & out_ready_i`. `in_ready_o` is 1 in the following cycle.
- Throughput: no overlap between operations. The minimum accept-to-accept spacing is j+3 cycles, or N+2 cycles for equal operands (with `out_ready_i` held high).
- `out_valid_o` and the result outputs stay constant while `out_ready_i` is low, for any number of cycles.
- `in_ready_o` and `out_valid_o` depend only on state. There is no combinational path from the inputs to these outputs.
- Reset asserted mid-SCAN or in DONE:
  - All state immediately returns to reset values and any pending result is discarded.
  - After reset deasserts, the first accept may occur on the first rising edge.

## Test plan
Default parameters unless noted (width=8, digit=2, sgn=0).
- Early exit: A=0xC3, B=0x3C -> GT=1, GE=1, EQ=0; `out_valid_o` high after E1 (latency 1).
- Equal operands: A=B=0x5A -> EQ=1, GE=1, GT=0; latency 4.
- Last-digit loss:
  - A=0x12, B=0x13 -> GE=0, GT=0, EQ=0; latency 4.
  - Swapped operands -> GT=1, GE=1; latency 4.
- Signed mode, sgn=1: A=0x80 (-128), B=0x7F (127) -> GE=0, latency 1. A=0xFF (-1), B=0xFE (-2) -> GT=1, latency 4.
- Backpressure and ignored input:
  - Hold `out_ready_i`=0 for 5 cycles in DONE; outputs and `out_valid_o` stay constant and `in_ready_o`=0.
  - Drive `in_valid_i`=1 with new operands during SCAN; they are not captured.
  - Sweep `digit` ∈ {1, 4, 8} with A=0x01, B=0x00; latency equals N.
- Reset mid-scan:
  - Assert `rst_i` during SCAN (A=0x12, B=0x13, cnt=2); outputs go to reset values asynchronously, before the next edge.
  - After deassertion, accept A=0x00, B=0xFF; expect GE=0 at latency 1, and no stale result appears.
